// File: rtl/tpu_dispatcher.sv
// Round-robin thread dispatcher: grants idle TPUs, streams instruction blocks with Nack retry, reports completions.
// Optional macro TPU_DISPATCH_TIMEOUT_EN aborts a dispatch after NACK_LIMIT consecutive Nack cycles.
module tpu_dispatcher #(
  parameter int NUM_TPU    = 4,
  parameter int ISSUE_W    = 8,
  parameter int INSTR_W    = 64,
  parameter int ADDR_W     = 10,
  parameter int NACK_LIMIT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Req,
  input  logic [ISSUE_W-1:0]         I_IssueNo,
  input  logic [ADDR_W-1:0]          I_Base,
  input  logic [ADDR_W-1:0]          I_Len,
  output logic                       O_Ack,
  output logic                       O_Err,
  output logic                       O_IMem_Re,
  output logic [ADDR_W-1:0]          O_IMem_Addr,
  input  logic [INSTR_W-1:0]         I_IMem_Instr,
  output logic [NUM_TPU-1:0]         O_TPU_Req,
  output logic                       O_TPU_End,
  output logic [INSTR_W-1:0]         O_TPU_Instr,
  output logic [ISSUE_W-1:0]         O_TPU_IssueNo,
  input  logic [NUM_TPU-1:0]         I_TPU_Nack,
  input  logic [NUM_TPU-1:0]         I_TPU_Term,
  input  logic [NUM_TPU*ISSUE_W-1:0] I_TPU_IssueNo,
  output logic                       O_Done,
  output logic [ISSUE_W-1:0]         O_Done_IssueNo,
  output logic [NUM_TPU-1:0]         O_Busy
);
  localparam int SEL_W = $clog2(NUM_TPU);
  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               state_q;
  logic [SEL_W-1:0]     ptr_q, sel_q;
  logic [NUM_TPU-1:0]   busy_q, busy_d, pend_q, pend_d;
  logic [ISSUE_W-1:0]   tiss_q [NUM_TPU];
  logic [ISSUE_W-1:0]   iss_q;
  logic [ADDR_W-1:0]    base_q, len_q, cnt_q;
  logic                 ack_q, err_q, rd0_q, dvld_q, hvld_q;
  logic [INSTR_W-1:0]   hold_q;

  logic                 in_send, present, nack_sel, accept, last, rd_next;
  logic                 grant, found, timeout, rep_vld;
  logic [SEL_W-1:0]     gsel, rep_idx;
  logic [NUM_TPU-1:0]   sel_oh, eligible;

  assign in_send  = (state_q == S_SEND);
  assign sel_oh   = NUM_TPU'(1) << sel_q;
  // An instruction is on the bus when fresh read data arrived or a Nacked word is being replayed.
  assign present  = in_send && (dvld_q || hvld_q);
  assign nack_sel = I_TPU_Nack[sel_q];
  assign accept   = present && !nack_sel;
  assign last     = (cnt_q == len_q - ADDR_W'(1));
  assign rd_next  = accept && !last;

  always_comb begin
    found = 1'b0;
    gsel  = ptr_q;
    for (int k = NUM_TPU - 1; k >= 0; k--) begin
      if (!busy_q[ptr_q + SEL_W'(k)]) begin
        found = 1'b1;
        gsel  = ptr_q + SEL_W'(k);
      end
    end
  end

  // ack_q blocks a second look at the same held request in the cycle its Ack is visible.
  assign grant = (state_q == S_IDLE) && I_Req && !ack_q && (I_Len != '0) && found;

  // A TPU still being streamed to is not reported until its SEND finishes.
  assign eligible = pend_q & ~(in_send ? sel_oh : '0);

  always_comb begin
    rep_vld = 1'b0;
    rep_idx = '0;
    for (int i = NUM_TPU - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        rep_vld = 1'b1;
        rep_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    if (rep_vld) begin
      busy_d[rep_idx] = 1'b0;
      pend_d[rep_idx] = 1'b0;
    end
    if (timeout) busy_d[sel_q] = 1'b0;
    if (grant)   busy_d[gsel]  = 1'b1;
    pend_d = pend_d | I_TPU_Term;
  end

`ifdef TPU_DISPATCH_TIMEOUT_EN
  localparam int NCNT_W = $clog2(NACK_LIMIT + 1);
  logic [NCNT_W-1:0] ncnt_q;

  assign timeout = present && nack_sel && (ncnt_q == NCNT_W'(NACK_LIMIT - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ncnt_q <= '0;
    end else if (present && nack_sel && !timeout) begin
      ncnt_q <= ncnt_q + NCNT_W'(1);
    end else begin
      ncnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      busy_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_TPU; i++) tiss_q[i] <= '0;
      iss_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd0_q   <= 1'b0;
      dvld_q  <= 1'b0;
      hvld_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rd0_q  <= 1'b0;
      dvld_q <= rd0_q || rd_next;
      for (int i = 0; i < NUM_TPU; i++) begin
        if (I_TPU_Term[i]) tiss_q[i] <= I_TPU_IssueNo[i*ISSUE_W +: ISSUE_W];
      end
      case (state_q)
        S_IDLE: begin
          if (I_Req && !ack_q) begin
            if (I_Len == '0) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else if (found) begin
              ack_q   <= 1'b1;
              rd0_q   <= 1'b1;
              sel_q   <= gsel;
              ptr_q   <= gsel + SEL_W'(1);
              iss_q   <= I_IssueNo;
              base_q  <= I_Base;
              len_q   <= I_Len;
              cnt_q   <= '0;
              hvld_q  <= 1'b0;
              state_q <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (present) begin
            if (nack_sel) begin
              if (!hvld_q) begin
                hold_q <= I_IMem_Instr;
                hvld_q <= 1'b1;
              end
              if (timeout) begin
                hvld_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              hvld_q <= 1'b0;
              cnt_q  <= cnt_q + ADDR_W'(1);
              if (last) state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_Ack          = ack_q;
  assign O_Err          = err_q || timeout;
  assign O_IMem_Re      = rd0_q || rd_next;
  assign O_IMem_Addr    = rd0_q ? base_q : (rd_next ? base_q + cnt_q + ADDR_W'(1) : '0);
  assign O_TPU_Req      = present ? sel_oh : '0;
  assign O_TPU_End      = present && last;
  assign O_TPU_Instr    = !present ? '0 : (hvld_q ? hold_q : I_IMem_Instr);
  assign O_TPU_IssueNo  = iss_q;
  assign O_Done         = rep_vld;
  assign O_Done_IssueNo = rep_vld ? tiss_q[rep_idx] : '0;
  assign O_Busy         = busy_q;

endmodule

// File: tb/tb_tpu_dispatcher.sv
// Directed bench for tpu_dispatcher: dispatch streams, round-robin, Nack replay, completion ordering, errors, reset.
module tb_tpu_dispatcher;
  localparam int NUM_TPU = 4;
  localparam int ISSUE_W = 8;
  localparam int INSTR_W = 64;
  localparam int ADDR_W  = 10;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       I_Req;
  logic [ISSUE_W-1:0]         I_IssueNo;
  logic [ADDR_W-1:0]          I_Base;
  logic [ADDR_W-1:0]          I_Len;
  logic                       O_Ack;
  logic                       O_Err;
  logic                       O_IMem_Re;
  logic [ADDR_W-1:0]          O_IMem_Addr;
  logic [INSTR_W-1:0]         I_IMem_Instr;
  logic [NUM_TPU-1:0]         O_TPU_Req;
  logic                       O_TPU_End;
  logic [INSTR_W-1:0]         O_TPU_Instr;
  logic [ISSUE_W-1:0]         O_TPU_IssueNo;
  logic [NUM_TPU-1:0]         I_TPU_Nack;
  logic [NUM_TPU-1:0]         I_TPU_Term;
  logic [NUM_TPU*ISSUE_W-1:0] I_TPU_IssueNo;
  logic                       O_Done;
  logic [ISSUE_W-1:0]         O_Done_IssueNo;
  logic [NUM_TPU-1:0]         O_Busy;

  int n_checks = 0;
  int n_errors = 0;

  tpu_dispatcher #(
    .NUM_TPU(NUM_TPU), .ISSUE_W(ISSUE_W), .INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .NACK_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .I_Req(I_Req), .I_IssueNo(I_IssueNo), .I_Base(I_Base), .I_Len(I_Len),
    .O_Ack(O_Ack), .O_Err(O_Err),
    .O_IMem_Re(O_IMem_Re), .O_IMem_Addr(O_IMem_Addr), .I_IMem_Instr(I_IMem_Instr),
    .O_TPU_Req(O_TPU_Req), .O_TPU_End(O_TPU_End), .O_TPU_Instr(O_TPU_Instr),
    .O_TPU_IssueNo(O_TPU_IssueNo), .I_TPU_Nack(I_TPU_Nack), .I_TPU_Term(I_TPU_Term),
    .I_TPU_IssueNo(I_TPU_IssueNo), .O_Done(O_Done), .O_Done_IssueNo(O_Done_IssueNo),
    .O_Busy(O_Busy)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] instr_of(input logic [ADDR_W-1:0] a);
    return 64'hF00D_0000_0000_0000 | 64'(a);
  endfunction

  // Instruction buffer: data one cycle after a read, junk otherwise.
  always @(posedge clock) begin
    if (O_IMem_Re) I_IMem_Instr <= instr_of(O_IMem_Addr);
    else           I_IMem_Instr <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic go();
    @(posedge clock);
    #2;
  endtask

  task automatic stream(input logic [ADDR_W-1:0] base, input int len,
                        input logic [NUM_TPU-1:0] oh, input logic [ISSUE_W-1:0] iss);
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + ADDR_W'(k);
      go(); #3;
      check("tpu_req",   64'(O_TPU_Req), 64'(oh));
      check("tpu_instr", O_TPU_Instr, instr_of(a));
      check("tpu_end",   64'(O_TPU_End), 64'(k == len - 1));
      check("tpu_issue", 64'(O_TPU_IssueNo), 64'(iss));
      if (k < len - 1) begin
        check("next_re",   64'(O_IMem_Re), 64'(1));
        check("next_addr", 64'(O_IMem_Addr), 64'(a + ADDR_W'(1)));
      end else begin
        check("last_no_re", 64'(O_IMem_Re), 64'(0));
      end
    end
    go(); #3;
    check("req_after_end", 64'(O_TPU_Req), 64'(0));
  endtask

  task automatic request(input logic [ISSUE_W-1:0] iss, input logic [ADDR_W-1:0] base,
                         input int len, input logic [NUM_TPU-1:0] oh,
                         input logic [NUM_TPU-1:0] busy_after);
    go();
    I_Req = 1'b1; I_IssueNo = iss; I_Base = base; I_Len = ADDR_W'(len);
    #3;
    check("ack_latency", 64'(O_Ack), 64'(0));
    go(); #3;
    check("ack",        64'(O_Ack), 64'(1));
    check("ack_no_err", 64'(O_Err), 64'(0));
    check("busy_grant", 64'(O_Busy), 64'(busy_after));
    check("first_re",   64'(O_IMem_Re), 64'(1));
    check("first_addr", 64'(O_IMem_Addr), 64'(base));
    check("no_req_ack", 64'(O_TPU_Req), 64'(0));
    I_Req = 1'b0;
    stream(base, len, oh, iss);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; I_Req = 1'b0; I_IssueNo = '0; I_Base = '0; I_Len = '0;
    I_TPU_Nack = '0; I_TPU_Term = '0; I_TPU_IssueNo = '0;
    repeat (3) @(posedge clock);
    #5;
    check("rst_ack",   64'(O_Ack), 64'(0));
    check("rst_err",   64'(O_Err), 64'(0));
    check("rst_re",    64'(O_IMem_Re), 64'(0));
    check("rst_addr",  64'(O_IMem_Addr), 64'(0));
    check("rst_req",   64'(O_TPU_Req), 64'(0));
    check("rst_end",   64'(O_TPU_End), 64'(0));
    check("rst_instr", O_TPU_Instr, 64'(0));
    check("rst_issue", 64'(O_TPU_IssueNo), 64'(0));
    check("rst_done",  64'(O_Done), 64'(0));
    check("rst_dissue",64'(O_Done_IssueNo), 64'(0));
    check("rst_busy",  64'(O_Busy), 64'(0));
    go(); reset = 1'b0; #3;

    // Basic 3-instruction dispatch to TPU0
    request(8'd5, 10'h010, 3, 4'b0001, 4'b0001);
    check("t1_busy", 64'(O_Busy), 64'(4'b0001));

    go(); reset = 1'b1; #3;
    check("rst2_busy", 64'(O_Busy), 64'(0));
    go(); reset = 1'b0; #3;

    // Round-robin over four idle TPUs, fifth request waits for a Term
    request(8'd10, 10'h020, 1, 4'b0001, 4'b0001);
    request(8'd11, 10'h021, 1, 4'b0010, 4'b0011);
    request(8'd12, 10'h022, 1, 4'b0100, 4'b0111);
    request(8'd13, 10'h023, 1, 4'b1000, 4'b1111);
    go();
    I_Req = 1'b1; I_IssueNo = 8'd20; I_Base = 10'h040; I_Len = 10'd2;
    #3;
    check("full_no_ack0", 64'(O_Ack), 64'(0));
    for (int i = 0; i < 2; i++) begin
      go(); #3;
      check("full_no_ack", 64'(O_Ack), 64'(0));
    end
    go(); I_TPU_Term = 4'b0100; I_TPU_IssueNo = {8'd0, 8'd12, 8'd0, 8'd0}; #3;
    check("term_no_done_yet", 64'(O_Done), 64'(0));
    go(); I_TPU_Term = '0; #3;
    check("done_tpu2",     64'(O_Done), 64'(1));
    check("done_tpu2_iss", 64'(O_Done_IssueNo), 64'(12));
    check("busy_at_report",64'(O_Busy), 64'(4'b1111));
    check("no_ack_report", 64'(O_Ack), 64'(0));
    go(); #3;
    check("busy_after_rep",64'(O_Busy), 64'(4'b1011));
    check("no_ack_yet",    64'(O_Ack), 64'(0));
    go(); #3;
    check("regrant_ack",   64'(O_Ack), 64'(1));
    check("regrant_busy",  64'(O_Busy), 64'(4'b1111));
    check("regrant_addr",  64'(O_IMem_Addr), 64'(10'h040));
    I_Req = 1'b0;
    stream(10'h040, 2, 4'b0100, 8'd20);

    // Two Terms in one cycle: lowest index first
    go(); I_TPU_Term = 4'b0101; I_TPU_IssueNo = {8'd0, 8'd9, 8'd0, 8'd7}; #3;
    check("dual_no_done", 64'(O_Done), 64'(0));
    go(); I_TPU_Term = '0; #3;
    check("dual_done0",     64'(O_Done), 64'(1));
    check("dual_done0_iss", 64'(O_Done_IssueNo), 64'(7));
    check("dual_busy0",     64'(O_Busy), 64'(4'b1111));
    go(); #3;
    check("dual_done2",     64'(O_Done), 64'(1));
    check("dual_done2_iss", 64'(O_Done_IssueNo), 64'(9));
    check("dual_busy2",     64'(O_Busy), 64'(4'b1110));
    go(); #3;
    check("dual_idle",      64'(O_Done), 64'(0));
    check("dual_idle_iss",  64'(O_Done_IssueNo), 64'(0));
    check("dual_busy_end",  64'(O_Busy), 64'(4'b1010));

    // Nack replay on second instruction, Term from the sending TPU deferred
    go(); I_Req = 1'b1; I_IssueNo = 8'd30; I_Base = 10'h100; I_Len = 10'd3; #3;
    go(); #3;
    check("nk_ack",  64'(O_Ack), 64'(1));
    check("nk_busy", 64'(O_Busy), 64'(4'b1011));
    I_Req = 1'b0;
    go(); I_TPU_Nack = 4'b0010; #3;
    check("nk_i0_req",   64'(O_TPU_Req), 64'(4'b0001));
    check("nk_i0_instr", O_TPU_Instr, instr_of(10'h100));
    check("nk_i0_addr",  64'(O_IMem_Addr), 64'(10'h101));
    go(); I_TPU_Nack = 4'b0001; I_TPU_Term = 4'b0001; I_TPU_IssueNo = {8'd0, 8'd0, 8'd0, 8'd31}; #3;
    check("nk_i1a_instr", O_TPU_Instr, instr_of(10'h101));
    check("nk_i1a_re",    64'(O_IMem_Re), 64'(0));
    check("nk_i1a_end",   64'(O_TPU_End), 64'(0));
    go(); I_TPU_Term = '0; #3;
    check("nk_i1b_req",   64'(O_TPU_Req), 64'(4'b0001));
    check("nk_i1b_instr", O_TPU_Instr, instr_of(10'h101));
    check("nk_i1b_re",    64'(O_IMem_Re), 64'(0));
    check("nk_defer1",    64'(O_Done), 64'(0));
    go(); I_TPU_Nack = '0; #3;
    check("nk_i1c_instr", O_TPU_Instr, instr_of(10'h101));
    check("nk_i1c_re",    64'(O_IMem_Re), 64'(1));
    check("nk_i1c_addr",  64'(O_IMem_Addr), 64'(10'h102));
    check("nk_defer2",    64'(O_Done), 64'(0));
    go(); #3;
    check("nk_i2_instr",  O_TPU_Instr, instr_of(10'h102));
    check("nk_i2_end",    64'(O_TPU_End), 64'(1));
    check("nk_defer3",    64'(O_Done), 64'(0));
    go(); #3;
    check("nk_stream_end",64'(O_TPU_Req), 64'(0));
    check("nk_done",      64'(O_Done), 64'(1));
    check("nk_done_iss",  64'(O_Done_IssueNo), 64'(31));
    go(); #3;
    check("nk_busy_end",  64'(O_Busy), 64'(4'b1010));

    // Zero-length request
    go(); I_Req = 1'b1; I_IssueNo = 8'd50; I_Base = 10'h300; I_Len = 10'd0; #3;
    check("z_no_ack_yet", 64'(O_Ack), 64'(0));
    go(); #3;
    check("z_ack",  64'(O_Ack), 64'(1));
    check("z_err",  64'(O_Err), 64'(1));
    check("z_req",  64'(O_TPU_Req), 64'(0));
    check("z_re",   64'(O_IMem_Re), 64'(0));
    check("z_busy", 64'(O_Busy), 64'(4'b1010));
    go(); I_Req = 1'b0; #3;
    check("z_ack_once", 64'(O_Ack), 64'(0));
    check("z_err_once", 64'(O_Err), 64'(0));
    check("z_busy2",    64'(O_Busy), 64'(4'b1010));

`ifdef TPU_DISPATCH_TIMEOUT_EN
    // Persistent Nack aborts on the 4th Nack cycle
    go(); I_Req = 1'b1; I_IssueNo = 8'd40; I_Base = 10'h200; I_Len = 10'd2; #3;
    go(); #3;
    check("to_ack",  64'(O_Ack), 64'(1));
    check("to_busy", 64'(O_Busy), 64'(4'b1110));
    I_Req = 1'b0;
    go(); I_TPU_Nack = 4'b0100; #3;
    check("to_req", 64'(O_TPU_Req), 64'(4'b0100));
    check("to_err1", 64'(O_Err), 64'(0));
    go(); #3;
    check("to_err2", 64'(O_Err), 64'(0));
    go(); #3;
    check("to_err3", 64'(O_Err), 64'(0));
    go(); #3;
    check("to_err4", 64'(O_Err), 64'(1));
    go(); I_TPU_Nack = '0; #3;
    check("to_err_clr", 64'(O_Err), 64'(0));
    check("to_busy_clr",64'(O_Busy), 64'(4'b1010));
    check("to_req_clr", 64'(O_TPU_Req), 64'(0));
    check("to_no_done", 64'(O_Done), 64'(0));
    request(8'd41, 10'h210, 1, 4'b0001, 4'b1011);
`endif

    // Reset in the middle of a SEND
    go(); I_Req = 1'b1; I_IssueNo = 8'd60; I_Base = 10'h180; I_Len = 10'd4; #3;
    go(); #3;
    check("mr_ack", 64'(O_Ack), 64'(1));
    I_Req = 1'b0;
    go(); I_TPU_Nack = 4'hF; #3;
    check("mr_sending", 64'(|O_TPU_Req), 64'(1));
    go(); reset = 1'b1; #3;
    check("mr_req",   64'(O_TPU_Req), 64'(0));
    check("mr_re",    64'(O_IMem_Re), 64'(0));
    check("mr_instr", O_TPU_Instr, 64'(0));
    check("mr_busy",  64'(O_Busy), 64'(0));
    check("mr_err",   64'(O_Err), 64'(0));
    check("mr_done",  64'(O_Done), 64'(0));
    go(); reset = 1'b0; I_TPU_Nack = '0; #3;
    for (int i = 0; i < 3; i++) begin
      go(); #3;
      check("mr_quiet_done", 64'(O_Done), 64'(0));
      check("mr_quiet_err",  64'(O_Err), 64'(0));
      check("mr_quiet_req",  64'(O_TPU_Req), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tpu_dispatcher.md
Name: tpu_dispatcher

Overview:
- MPU-side scheduler that assigns thread dispatch requests to one of NUM_TPU idle TPUs using round-robin selection.
- Streams the thread's instruction block from the MPU instruction buffer into the selected TPU's front end, retrying on Nack.
- Tracks per-TPU busy state and reports thread completion, with issue number, back to the MPU commit logic.

Parameters:
- NUM_TPU, 4, number of TPUs served (power of two, ≥2)
- ISSUE_W, 8, thread issue-number width
- INSTR_W, 64, instruction word width
- ADDR_W, 10, instruction-buffer address width; also the length width
- NACK_LIMIT, 255, consecutive-Nack abort threshold (used only with the optional feature)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- I_Req  in  1  dispatch request (level; held until O_Ack)
- I_IssueNo  in  ISSUE_W  issue number of the requested thread
- I_Base  in  ADDR_W  first instruction address
- I_Len  in  ADDR_W  instruction count
- O_Ack  out  1  one-cycle pulse: request accepted
- O_Err  out  1  one-cycle pulse: request rejected or dispatch aborted
- O_IMem_Re  out  1  instruction-buffer read enable
- O_IMem_Addr  out  ADDR_W  read address
- I_IMem_Instr  in  INSTR_W  read data, valid 1 cycle after O_IMem_Re
- O_TPU_Req  out  NUM_TPU  one-hot instruction valid, per TPU
- O_TPU_End  out  1  marks the last instruction of the thread (qualifies O_TPU_Req)
- O_TPU_Instr  out  INSTR_W  instruction word, shared by all TPUs
- O_TPU_IssueNo  out  ISSUE_W  issue number of the thread being sent
- I_TPU_Nack  in  NUM_TPU  per-TPU not-acknowledge, same cycle as Req
- I_TPU_Term  in  NUM_TPU  per-TPU termination pulse
- I_TPU_IssueNo  in  NUM_TPU*ISSUE_W  per-TPU issue number, valid with Term
- O_Done  out  1  completion pulse
- O_Done_IssueNo  out  ISSUE_W  issue number of the completed thread
- O_Busy  out  NUM_TPU  per-TPU busy flags

Behaviour:
- Reset values:
  - all outputs are 0; state is IDLE
  - round-robin pointer is 0
  - busy and term-pending bits are cleared
- Reset asserted mid-operation aborts any dispatch immediately; no O_Done or O_Err is emitted for it.
- IDLE:
  - Acts on I_Req=1.
  - If I_Len==0: pulse O_Err and O_Ack together, stay in IDLE.
  - Else, if any TPU has busy=0: pick the first idle TPU at or after the pointer (wrapping), set busy[sel], latch IssueNo/Base/Len, pulse O_Ack, issue read of Base, go to SEND. The pointer becomes sel+1 mod NUM_TPU.
  - If no TPU is idle: hold in IDLE with no Ack.
- SEND:
  - Drive O_TPU_Req[sel]=1 with the current instruction; O_TPU_End=1 when count==Len-1.
  - If Nack[sel]=0: the instruction is accepted and count increments.
    - If it was the last instruction: go to IDLE next cycle.
    - Otherwise: read the next address in the same cycle.
  - If Nack[sel]=1: re-present the same instruction from a hold register next cycle; no new read is issued.
  - Throughput is 1 instruction/cycle without Nack. Latency from O_Ack to the first O_TPU_Req is 1 cycle.
- Completion:
  - I_TPU_Term[i] sets pending[i] and captures I_TPU_IssueNo[i].
  - Each cycle, the lowest-index pending TPU is reported on O_Done/O_Done_IssueNo; its pending and busy bits are cleared the same cycle.
  - A TPU stays busy until it is reported, so it cannot be re-granted earlier.
- Simultaneous events:
  - Term for TPU i and a new I_Req in the same cycle: TPU i becomes grantable in the cycle after its report.
  - Multiple Terms in one cycle: reported in successive cycles, lowest index first.
- Term from a TPU that is still in SEND: recorded as pending; reported after SEND ends for that TPU.

Optional Feature:
- Macro: TPU_DISPATCH_TIMEOUT_EN.
- Defined:
  - A counter tracks consecutive Nack cycles in SEND.
  - On reaching NACK_LIMIT: pulse O_Err, clear busy[sel], return to IDLE.
  - The partial thread is not reported on O_Done.
- Undefined: no counter exists; SEND waits on Nack indefinitely.

Test Plan:
- Reset, then I_Req IssueNo=5 Base=0x010 Len=3, no Nack → O_Ack at cycle 1; TPU0 receives addresses 0x010, 0x011, 0x012 on consecutive cycles; End on the third; O_Busy=0001.
- Four requests with Len=1 while all TPUs are idle → granted to TPU0, 1, 2, 3 in order; a fifth request is held with no Ack until a Term arrives.
- Nack[sel]=1 for 2 cycles on the second instruction → the same instruction is re-presented 3 times, the third instruction follows, and the total stream takes 5 cycles.
- I_TPU_Term=0101 with IssueNo 7 (TPU0) and 9 (TPU2) in one cycle → O_Done 7 next cycle, then O_Done 9; O_Busy clears bit 0, then bit 2.
- I_Len=0 → O_Ack=1 and O_Err=1 in the same cycle; no TPU Req; busy unchanged.
- With TPU_DISPATCH_TIMEOUT_EN and NACK_LIMIT=4: persistent Nack → O_Err on the 4th Nack cycle, busy[sel]=0, state IDLE; reset mid-SEND → all outputs 0 next edge.
